mux_src_sequencer: RTL and testbench

//   Upstream stage of the 8-bit 8:1 mux. Holds the eight 8-bit source registers

---
 rtl/mux_src_sequencer.sv | 135 +++++++++++++
 tb/tb_mux_src_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_src_sequencer.sv
// Source registers and scan sequencer feeding the 8-bit 8:1 mux.
// Walks enabled channels in ascending order and flags each settled one.
module mux_src_sequencer #(
    parameter int DWELL = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WE,
    input  logic [2:0] WADDR,
    input  logic [7:0] WDATA,
    input  logic       START,
    input  logic       CONT,
    input  logic [7:0] MASK,
    output logic [7:0] I0,
    output logic [7:0] I1,
    output logic [7:0] I2,
    output logic [7:0] I3,
    output logic [7:0] I4,
    output logic [7:0] I5,
    output logic [7:0] I6,
    output logic [7:0] I7,
    output logic [2:0] S,
    output logic       VALID,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  regs [8];
    logic [7:0]  mask_q;
    logic [7:0]  cnt;
    logic [7:0]  above;
    logic [3:0]  first;
    logic [3:0]  nxt;
    logic        launch;

    // {found, index} of the lowest set bit
    function automatic logic [3:0] lowest(input logic [7:0] m);
        logic [3:0] r;
        r = '0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    assign above  = mask_q & (8'hFE << S);
    assign first  = lowest(MASK);
    assign nxt    = lowest(above);
    assign launch = (state == IDLE && START) ||
                    (state == DONE_ST && CONT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 8; k++) regs[k] <= '0;
        end else if (WE) begin
            regs[WADDR] <= WDATA;
        end
    end

    assign I0 = regs[0];
    assign I1 = regs[1];
    assign I2 = regs[2];
    assign I3 = regs[3];
    assign I4 = regs[4];
    assign I5 = regs[5];
    assign I6 = regs[6];
    assign I7 = regs[7];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            mask_q <= '0;
            cnt    <= '0;
            S      <= '0;
            VALID  <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else if (launch) begin
            mask_q <= MASK;
            if (first[3]) begin
                state <= SCAN;
                S     <= first[2:0];
                cnt   <= DWELL_M1;
                BUSY  <= 1'b1;
                VALID <= (DWELL_M1 == 8'd0);
                DONE  <= 1'b0;
            end else begin
                state <= DONE_ST;
                BUSY  <= 1'b0;
                VALID <= 1'b0;
                DONE  <= 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                end
                SCAN: begin
                    if (cnt != 8'd0) begin
                        cnt   <= cnt - 8'd1;
                        VALID <= (cnt == 8'd1);
                    end else if (nxt[3]) begin
                        S     <= nxt[2:0];
                        cnt   <= DWELL_M1;
                        VALID <= (DWELL_M1 == 8'd0);
                    end else begin
                        state <= DONE_ST;
                        BUSY  <= 1'b0;
                        VALID <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_src_sequencer.sv
// Scoreboard bench for mux_src_sequencer with DWELL=1 and DWELL=3 instances.
// Directed scans push expected VALID/DONE events; monitors pop and compare.
module tb_mux_src_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       WE = 1'b0;
    logic [2:0] WADDR = '0;
    logic [7:0] WDATA = '0;
    logic       START = 1'b0;
    logic       CONT = 1'b0;
    logic [7:0] MASK = '0;

    logic [7:0] u1_i [8];
    logic [7:0] u3_i [8];
    logic [2:0] s1, s3;
    logic       v1, v3, b1, b3, d1, d3;

    typedef struct packed {
        logic       dn;
        logic [2:0] s;
        logic [7:0] d;
    } ev_t;

    ev_t        q1[$];
    ev_t        q3[$];
    logic [7:0] mdl [8];
    bit         sb_on = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [5:0] t3 [5] = '{6'b000_110, 6'b010_110, 6'b111_110,
                           6'b111_001, 6'b111_000};
    logic [5:0] t4 [8] = '{6'b000_010, 6'b000_010, 6'b000_110,
                           6'b001_010, 6'b001_010, 6'b001_110,
                           6'b001_001, 6'b001_000};
    logic [5:0] t5 [6] = '{6'b111_110, 6'b111_001, 6'b111_110,
                           6'b111_001, 6'b111_110, 6'b111_001};

    always #5 CLK = ~CLK;

    mux_src_sequencer #(.DWELL(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .START(START), .CONT(CONT), .MASK(MASK),
        .I0(u1_i[0]), .I1(u1_i[1]), .I2(u1_i[2]), .I3(u1_i[3]),
        .I4(u1_i[4]), .I5(u1_i[5]), .I6(u1_i[6]), .I7(u1_i[7]),
        .S(s1), .VALID(v1), .BUSY(b1), .DONE(d1)
    );

    mux_src_sequencer #(.DWELL(3)) u3 (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .START(START), .CONT(CONT), .MASK(MASK),
        .I0(u3_i[0]), .I1(u3_i[1]), .I2(u3_i[2]), .I3(u3_i[3]),
        .I4(u3_i[4]), .I5(u3_i[5]), .I6(u3_i[6]), .I7(u3_i[7]),
        .S(s3), .VALID(v3), .BUSY(b3), .DONE(d3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_scan(input logic [7:0] m);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                q1.push_back({1'b0, 3'(k), mdl[k]});
                q3.push_back({1'b0, 3'(k), mdl[k]});
            end
        end
        q1.push_back({1'b1, 3'd0, 8'd0});
        q3.push_back({1'b1, 3'd0, 8'd0});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        WE = 1'b1; WADDR = a; WDATA = d;
        @(negedge CLK);
        WE = 1'b0;
        mdl[a] = d;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!b1 && !d1 && !b3 && !d3) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    always @(negedge CLK) begin
        ev_t e;
        if (sb_on && (v1 || d1)) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL sb1_extra actual=s%0d v%0b d%0b expected=none",
                         s1, v1, d1);
            end else begin
                e = q1.pop_front();
                if (e.dn !== d1 || (!e.dn && (e.s !== s1 || e.d !== u1_i[s1]))) begin
                    miscompares++;
                    $display("FAIL sb1 actual=d%0b s%0d y%0h expected=d%0b s%0d y%0h",
                             d1, s1, u1_i[s1], e.dn, e.s, e.d);
                end
            end
        end
    end

    always @(negedge CLK) begin
        ev_t e;
        if (sb_on && (v3 || d3)) begin
            vectors++;
            if (q3.size() == 0) begin
                miscompares++;
                $display("FAIL sb3_extra actual=s%0d v%0b d%0b expected=none",
                         s3, v3, d3);
            end else begin
                e = q3.pop_front();
                if (e.dn !== d3 || (!e.dn && (e.s !== s3 || e.d !== u3_i[s3]))) begin
                    miscompares++;
                    $display("FAIL sb3 actual=d%0b s%0d y%0h expected=d%0b s%0d y%0h",
                             d3, s3, u3_i[s3], e.dn, e.s, e.d);
                end
            end
        end
    end

    initial begin
        bit saw_done;
        for (int k = 0; k < 8; k++) mdl[k] = '0;

        // reset state
        #12;
        chk("rst_u1_flags", {s1, v1, b1, d1}, 6'd0);
        chk("rst_u3_flags", {s3, v3, b3, d3}, 6'd0);
        chk("rst_i7", u1_i[7], 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        sb_on = 1'b1;

        // write then read
        wr(3'd5, 8'hA5);
        for (int k = 0; k < 8; k++) chk($sformatf("wr_u1_i%0d", k), u1_i[k], mdl[k]);
        chk("wr_u3_i5", u3_i[5], 8'hA5);
        wr(3'd0, 8'h11);
        wr(3'd2, 8'h22);
        wr(3'd7, 8'h77);
        wr(3'd1, 8'h33);
        wr(3'd3, 8'h44);

        // sparse scan, cycle-exact on DWELL=1
        @(negedge CLK);
        START = 1'b1; MASK = 8'b1000_0101;
        push_scan(8'b1000_0101);
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sparse_c%0d", i), {s1, v1, b1, d1}, t3[i]);
            @(negedge CLK);
        end
        wait_idle();

        // long dwell, cycle-exact on DWELL=3
        START = 1'b1; MASK = 8'h03;
        push_scan(8'h03);
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dwell3_c%0d", i), {s3, v3, b3, d3}, t4[i]);
            @(negedge CLK);
        end
        wait_idle();

        // empty mask goes straight to DONE
        START = 1'b1; MASK = 8'h00;
        q1.push_back({1'b1, 3'd0, 8'd0});
        q3.push_back({1'b1, 3'd0, 8'd0});
        @(negedge CLK);
        START = 1'b0;
        chk("empty_u1", {v1, b1, d1}, 3'b001);
        chk("empty_u3", {v3, b3, d3}, 3'b001);
        @(negedge CLK);
        wait_idle();

        // continuous mode on channel 7
        sb_on = 1'b0;
        START = 1'b1; MASK = 8'h80; CONT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cont_c%0d", i), {s1, v1, b1, d1}, t5[i]);
            if (i < 5) @(negedge CLK);
        end
        CONT = 1'b0;
        @(negedge CLK);
        wait_idle();
        sb_on = 1'b1;

        // START and MASK changes mid-scan are ignored
        START = 1'b1; MASK = 8'h0F;
        push_scan(8'h0F);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1; MASK = 8'hF0;
        @(negedge CLK);
        START = 1'b0;
        wait_idle();
        @(negedge CLK);
        chk("hazard_q1_empty", q1.size(), 0);
        chk("hazard_q3_empty", q3.size(), 0);

        // asynchronous reset mid-scan
        sb_on = 1'b0;
        START = 1'b1; MASK = 8'hFF;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_u1", {s1, v1, b1, d1}, 6'd0);
        chk("midrst_u3", {s3, v3, b3, d3}, 6'd0);
        chk("midrst_i5", u1_i[5], 8'h00);
        for (int k = 0; k < 8; k++) mdl[k] = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (d1 || d3 || b1 || b3) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 1'b0);
        sb_on = 1'b1;

        // single channel after reset
        wr(3'd6, 8'h5C);
        @(negedge CLK);
        START = 1'b1; MASK = 8'h40;
        push_scan(8'h40);
        @(negedge CLK);
        START = 1'b0;
        wait_idle();
        @(negedge CLK);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q3_empty", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
